// File: rtl/adder_tree_pipe.sv
// Pipelined multi-operand signed adder: registered binary tree, then one
// format stage (wrap / saturate / scale) with a sticky overflow flag.

module adder_tree_node #(
  parameter int FW = 18
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic [FW-1:0] i_a,
  input  logic [FW-1:0] i_b,
  output logic [FW-1:0] o_sum
);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)  o_sum <= '0;
    else if (i_en) o_sum <= i_a + i_b;
endmodule

module adder_tree_pipe #(
  parameter int WORD_SIZE  = 16,
  parameter int NUM_INPUTS = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [NUM_INPUTS*WORD_SIZE-1:0] i_data,
  input  logic [1:0]                      i_mode,
  input  logic                            i_valid,
  output logic                            o_ready,
  output logic [WORD_SIZE-1:0]            o_data,
  output logic                            o_valid,
  input  logic                            i_ready,
  input  logic                            i_clr_ovf,
  output logic                            o_ovf
);
  localparam int W      = WORD_SIZE;
  localparam int LVL    = $clog2(NUM_INPUTS);
  localparam int FW     = W + LVL;
  localparam int P      = 1 << LVL;
  localparam int STAGES = LVL + 1;

  logic                  en;
  logic [STAGES:1]       vld_pipe;
  logic [LVL:1][1:0]     mode_pipe;
  logic [P-1:0][FW-1:0]  leaf;

  // Stall is decided by the output stage alone, so bubbles never block.
  assign en      = !o_valid || i_ready;
  assign o_ready = en;
  assign o_valid = vld_pipe[STAGES];

  // Sign-extend to full precision; unused leaves are zero.
  always_comb begin
    leaf = '0;
    for (int k = 0; k < NUM_INPUTS; k++)
      leaf[k] = FW'($signed(i_data[k*W +: W]));
  end

  for (genvar l = 1; l <= LVL; l++) begin : g_lvl
    localparam int N = P >> l;
    logic [2*N-1:0][FW-1:0] src;
    logic [N-1:0][FW-1:0]   sum;
    if (l == 1) begin : g_first
      assign src = leaf;
    end else begin : g_next
      assign src = g_lvl[l-1].sum;
    end
    for (genvar j = 0; j < N; j++) begin : g_node
      adder_tree_node #(.FW(FW)) u_node (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (en),
        .i_a     (src[2*j]),
        .i_b     (src[2*j+1]),
        .o_sum   (sum[j])
      );
    end
  end

  logic [FW-1:0] tot;
  logic          over;
  logic          ovf_hit;
  logic [W-1:0]  fmt_data;

  assign tot = g_lvl[LVL].sum[0];

  // Fits in W bits only if the top LVL+1 bits are a pure sign extension.
  assign over    = !((&tot[FW-1:W-1]) || !(|tot[FW-1:W-1]));
  assign ovf_hit = vld_pipe[LVL] && over && (mode_pipe[LVL] != 2'b10);

  always_comb begin
    fmt_data = tot[W-1:0];
    case (mode_pipe[LVL])
      2'b01: if (over) fmt_data = tot[FW-1] ? {1'b1, {(W-1){1'b0}}}
                                            : {1'b0, {(W-1){1'b1}}};
      2'b10: fmt_data = tot[FW-1:LVL];
      default: fmt_data = tot[W-1:0];
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_pipe  <= '0;
      mode_pipe <= '0;
      o_data    <= '0;
    end else if (en) begin
      vld_pipe     <= {vld_pipe[STAGES-1:1], i_valid};
      mode_pipe[1] <= i_mode;
      for (int s = 2; s <= LVL; s++)
        mode_pipe[s] <= mode_pipe[s-1];
      o_data <= fmt_data;
    end
  end

  // A new overflow beats a simultaneous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              o_ovf <= 1'b0;
    else if (en && ovf_hit)    o_ovf <= 1'b1;
    else if (i_clr_ovf)        o_ovf <= 1'b0;
  end
endmodule

// File: tb/tb_adder_tree_pipe.sv
// Self-checking bench for adder_tree_pipe: directed corner beats, backpressure,
// random stream against an integer reference model, mid-stream reset, N=3 variant.

module tb_adder_tree_pipe;
  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [63:0] i_data;
  logic [1:0]  i_mode;
  logic        i_valid, o_ready, o_valid, i_ready, i_clr_ovf, o_ovf;
  logic [15:0] o_data;

  logic [47:0] b_data;
  logic [1:0]  b_mode;
  logic        b_valid, b_oready, b_ovalid, b_ovf;
  logic [15:0] b_odata;

  always #5 i_clk = ~i_clk;

  adder_tree_pipe #(.WORD_SIZE(16), .NUM_INPUTS(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_mode(i_mode),
    .i_valid(i_valid), .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .i_clr_ovf(i_clr_ovf), .o_ovf(o_ovf)
  );

  adder_tree_pipe #(.WORD_SIZE(16), .NUM_INPUTS(3)) dut3 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(b_data), .i_mode(b_mode),
    .i_valid(b_valid), .o_ready(b_oready), .o_data(b_odata), .o_valid(b_ovalid),
    .i_ready(1'b1), .i_clr_ovf(1'b0), .o_ovf(b_ovf)
  );

  typedef struct { logic [15:0] d; bit ov; } beat_t;

  int    n_chk = 0, n_fail = 0, pops = 0;
  beat_t q[$];
  bit    exp_ovf = 1'b0, ovf_chk = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer sum, then the three formatting rules.
  function automatic beat_t model(logic [63:0] d, logic [1:0] m);
    beat_t r;
    int s = 0;
    int v;
    for (int k = 0; k < 4; k++) s += int'($signed(d[k*16 +: 16]));
    r.ov = (s > 32767 || s < -32768) && (m != 2'd2);
    case (m)
      2'd1:    v = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
      2'd2:    v = s >>> 2;
      default: v = s;
    endcase
    r.d = v[15:0];
    return r;
  endfunction

  function automatic logic [63:0] pk4(int a, int b, int c, int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // Scoreboard: record accepted beats, match departing beats in order.
  always @(negedge i_clk) begin
    beat_t e;
    if (i_rst_n) begin
      if (o_valid && i_ready) begin
        n_chk++;
        assert (q.size() != 0) else begin
          n_fail++;
          $error("FAIL spurious_beat: observed %0h expected none", o_data);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          pops++;
          chk("sb_data", o_data, e.d);
          exp_ovf = exp_ovf | e.ov;
          if (ovf_chk) chk("sb_ovf", o_ovf, exp_ovf);
        end
      end
      if (i_valid && o_ready) q.push_back(model(i_data, i_mode));
    end
  end

  task automatic idle(int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic send(logic [63:0] d, logic [1:0] m);
    bit acc = 1'b0;
    i_data = d; i_mode = m; i_valid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge i_clk); acc = o_ready;
      @(posedge i_clk); #1;
      if (acc) break;
    end
    i_valid = 1'b0;
    chk("send_accept", acc, 1);
  endtask

  task automatic wait_out();
    for (int t = 0; t < 20; t++) begin
      if (o_valid) break;
      idle(1);
    end
    chk("out_timeout", o_valid, 1);
  endtask

  task automatic clr_pulse();
    i_clr_ovf = 1'b1; idle(1); i_clr_ovf = 1'b0;
  endtask

  task automatic drain(string tag);
    for (int t = 0; t < 60; t++) begin
      if (q.size() == 0) break;
      idle(1);
    end
    chk(tag, q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] hold;
    int p0;
    i_rst_n = 1'b1; i_data = '0; i_mode = '0; i_valid = 1'b0;
    i_ready = 1'b1; i_clr_ovf = 1'b0;
    b_data = '0; b_mode = '0; b_valid = 1'b0;
    #1 i_rst_n = 1'b0;
    #2;
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_ready", o_ready, 1);
    idle(2);
    i_rst_n = 1'b1;
    idle(1);

    // {1,2,3,4} wrap: 3-cycle latency
    i_data = pk4(1, 2, 3, 4); i_mode = 2'd0; i_valid = 1'b1;
    idle(1); i_valid = 1'b0;
    chk("lat_c1", o_valid, 0);
    idle(1); chk("lat_c2", o_valid, 0);
    idle(1); chk("lat_c3", o_valid, 1);
    chk("sum_1234", o_data, 16'd10);
    chk("ovf_1234", o_ovf, 0);
    idle(2);

    send(pk4(32767, 32767, 32767, 32767), 2'd0); wait_out();
    chk("max_wrap", o_data, 16'hFFFC);
    chk("max_wrap_ovf", o_ovf, 1);
    idle(2); clr_pulse();
    chk("clr_ovf", o_ovf, 0);

    send(pk4(32767, 32767, 32767, 32767), 2'd1); wait_out();
    chk("max_sat", o_data, 16'h7FFF);
    chk("max_sat_ovf", o_ovf, 1);
    idle(2); clr_pulse();

    send(pk4(32767, 32767, 32767, 32767), 2'd2); wait_out();
    chk("max_scale", o_data, 16'h7FFF);
    chk("max_scale_ovf", o_ovf, 0);
    idle(2);

    // clear held across the overflowing load: set must win
    i_clr_ovf = 1'b1;
    send(pk4(32767, 32767, 32767, 32767), 2'd0); wait_out();
    chk("set_wins", o_ovf, 1);
    idle(1);
    chk("clr_after", o_ovf, 0);
    i_clr_ovf = 1'b0;
    idle(2);

    send(pk4(-32768, -32768, -32768, -32768), 2'd1); wait_out();
    chk("min_sat", o_data, 16'h8000);
    chk("min_sat_ovf", o_ovf, 1);
    idle(2); clr_pulse();
    send(pk4(-32768, -32768, -32768, -32768), 2'd2); wait_out();
    chk("min_scale", o_data, 16'h8000);
    chk("min_scale_ovf", o_ovf, 0);
    idle(2);
    send(pk4(-1, -1, -1, -1), 2'd0); wait_out();
    chk("neg1_wrap", o_data, 16'hFFFC);
    chk("neg1_ovf", o_ovf, 0);
    idle(3);

    // backpressure: 8 beats, 5-cycle stall mid-stream
    p0 = pops;
    fork
      begin
        for (int b = 0; b < 8; b++) send(pk4(b, b, b, b), 2'd0);
      end
      begin
        idle(5);
        chk("bp_valid", o_valid, 1);
        i_ready = 1'b0; #1;
        hold = o_data;
        chk("bp_ready0", o_ready, 0);
        for (int c = 0; c < 5; c++) begin
          @(posedge i_clk); #1;
          chk("bp_stable", o_data, hold);
          chk("bp_vstable", o_valid, 1);
          chk("bp_ready", o_ready, 0);
        end
        i_ready = 1'b1;
      end
    join
    drain("bp_drain");
    chk("bp_count", pops - p0, 8);

    // random stream with random backpressure
    idle(2); clr_pulse();
    exp_ovf = 1'b0; ovf_chk = 1'b1;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          if ($urandom_range(3) == 0) idle(1);
          send({$urandom, $urandom}, 2'($urandom_range(3)));
        end
      end
      begin
        for (int c = 0; c < 100; c++) begin
          i_ready = ($urandom_range(3) != 0);
          idle(1);
        end
        i_ready = 1'b1;
      end
    join
    i_ready = 1'b1;
    drain("rnd_drain");
    ovf_chk = 1'b0;
    idle(2); clr_pulse();

    // reset with two beats in flight, first one parked at the output
    send(pk4(32767, 32767, 32767, 32767), 2'd0);
    send(pk4(100, 0, 0, 0), 2'd0);
    i_ready = 1'b0;
    idle(2);
    chk("pre_rst_valid", o_valid, 1);
    chk("pre_rst_ovf", o_ovf, 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_data", o_data, 0);
    chk("arst_ovf", o_ovf, 0);
    q.delete();
    idle(2);
    i_ready = 1'b1;
    i_rst_n = 1'b1;
    i_data = pk4(1, 1, 1, 1); i_mode = 2'd0; i_valid = 1'b1;
    chk("post_rst_ready", o_ready, 1);
    idle(1); i_valid = 1'b0;
    chk("post_rst_c1", o_valid, 0);
    idle(1); chk("post_rst_c2", o_valid, 0);
    idle(1); chk("post_rst_c3", o_valid, 1);
    chk("post_rst_data", o_data, 16'd4);
    idle(2);
    chk("post_rst_q", q.size(), 0);

    // NUM_INPUTS=3 variant
    b_data = {16'd7, 16'd6, 16'd5}; b_mode = 2'd0; b_valid = 1'b1;
    idle(1); b_valid = 1'b0;
    chk("n3_c1", b_ovalid, 0);
    idle(1); chk("n3_c2", b_ovalid, 0);
    idle(1); chk("n3_c3", b_ovalid, 1);
    chk("n3_wrap", b_odata, 16'd18);
    idle(2);
    b_mode = 2'd2; b_valid = 1'b1;
    idle(1); b_valid = 1'b0;
    idle(2);
    chk("n3_scale_v", b_ovalid, 1);
    chk("n3_scale", b_odata, 16'd4);
    chk("n3_ovf", b_ovf, 0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
